// File: rtl/sp_ram_fifo_pkg.sv
// Shared types and helpers for the single-port-RAM FIFO controller.
package sp_ram_fifo_pkg;

  typedef enum logic {Read, Write} grant_e;

  // Pointer increment with natural wrap at 2**width.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned width);
    return (ptr + 1) % (32'd1 << width);
  endfunction

endpackage

// File: rtl/sp_ram_fifo_ctrl.sv
// Valid/ready FIFO built on one external single_port_ram; round-robin write/prefetch arbitration.
// Optional high-water mark: define SP_RAM_FIFO_PEAK_EN for peak_count/peak_clr.
module sp_ram_fifo_ctrl
  import sp_ram_fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_ready,
`ifdef SP_RAM_FIFO_PEAK_EN
  input  logic                  peak_clr,
  output logic [ADDR_WIDTH:0]   peak_count,
`endif
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_out,
  output logic [ADDR_WIDTH:0]   mem_count
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  rd_valid_q, inflight_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  grant_e                last_grant_q;

  logic full, empty, read_want, write_want, grant_rd, grant_wr, conflict;

  always_comb begin
    full       = (count_q == (ADDR_WIDTH + 1)'(Depth));
    empty      = (count_q == '0);
    // Only prefetch when the output register is guaranteed free on return.
    read_want  = !empty && !inflight_q && (!rd_valid_q || rd_ready);
    write_want = wr_valid && !full;
    conflict   = read_want && write_want;
    grant_rd   = read_want && !(write_want && last_grant_q == Read);
    grant_wr   = write_want && !grant_rd;
    wr_ready   = !full && !grant_rd;

    ram_we   = grant_wr;
    ram_addr = grant_wr ? wr_ptr_q : rd_ptr_q;
    ram_data = grant_wr ? wr_data : '0;

    count_d = count_q;
    if (grant_wr) begin
      count_d = count_q + 1'b1;
    end else if (grant_rd) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      inflight_q   <= 1'b0;
      last_grant_q <= Read;
    end else begin
      count_q    <= count_d;
      inflight_q <= grant_rd;
      if (grant_wr) begin
        wr_ptr_q <= ADDR_WIDTH'(ptr_inc(32'(wr_ptr_q), ADDR_WIDTH));
      end
      if (grant_rd) begin
        rd_ptr_q <= ADDR_WIDTH'(ptr_inc(32'(rd_ptr_q), ADDR_WIDTH));
      end
      if (conflict) begin
        last_grant_q <= grant_rd ? Read : Write;
      end
      if (inflight_q) begin
        rd_data_q  <= ram_out;
        rd_valid_q <= 1'b1;
      end else if (rd_valid_q && rd_ready) begin
        rd_valid_q <= 1'b0;
      end
    end
  end

  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign mem_count = count_q;

`ifdef SP_RAM_FIFO_PEAK_EN
  logic [ADDR_WIDTH:0] peak_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      peak_q <= '0;
    end else if (peak_clr) begin
      peak_q <= '0;
    end else if (count_d > peak_q) begin
      peak_q <= count_d;
    end
  end

  assign peak_count = peak_q;
`endif

endmodule
